// File: rtl/tmr_pkg.sv
// Shared types and constants for the timer/PWM core.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_CENTER = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } run_st_e;

    localparam int FLG_UEV    = 0;
    localparam int FLG_FAULT  = 1;
    localparam int FLG_MATCH0 = 2;

endpackage

// File: rtl/tmr_pwm_ch.sv
// One PWM channel: shadowed compare, registered compare result, match pulse and
// polarity/fault gating of the output.
module tmr_pwm_ch
    import tmr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [WIDTH-1:0] cmp_in,
    input  logic             load,
    input  logic             tick,
    input  logic [WIDTH-1:0] count_next,
    input  logic             running,
    input  logic             fault_q,
    input  logic             pol,
    output logic             pwm,
    output logic             match
);

    logic [WIDTH-1:0] cmp_sh_q, cmp_sh_d;
    logic             raw_q, raw_d;

    always_comb begin
        cmp_sh_d = cmp_sh_q;
        raw_d    = raw_q;
        if (load) begin
            cmp_sh_d = cmp_in;
        end
        // Compare against the count being loaded this tick, so raw lines up with count.
        if (tick) begin
            raw_d = (count_next < cmp_sh_q);
        end
    end

    assign match = tick & (count_next == cmp_sh_q);
    assign pwm   = pol ^ (raw_q & running & ~fault_q);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cmp_sh_q <= '0;
            raw_q    <= 1'b0;
        end else begin
            cmp_sh_q <= cmp_sh_d;
            raw_q    <= raw_d;
        end
    end

endmodule

// File: rtl/tmr_pwm_core.sv
// Timer/PWM core: prescaler, up/down/centre counter with shadowed period,
// one-shot sequencing, fault latch, sticky flags and CHANNELS compare channels.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | en low (or first en-high cycle); count preset, shadows track
// ST_RUN  | counting on prescaler ticks
// ST_DONE | one-shot finished; holds until en goes low
module tmr_pwm_core
    import tmr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int PRE_W    = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      one_shot,
    input  logic [PRE_W-1:0]          prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] cmp,
    input  logic [CHANNELS-1:0]       pol,
    input  logic                      fault,
    input  logic                      fault_en,
    input  logic                      fault_clr,
    input  logic [CHANNELS+1:0]       flag_clr,
    output logic [WIDTH-1:0]          count,
    output logic                      dir,
    output logic                      running,
    output logic [CHANNELS-1:0]       pwm,
    output logic [CHANNELS+1:0]       flags
);

    run_st_e              st_q, st_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 dir_q, dir_d;
    logic [WIDTH-1:0]     psh_q, psh_d;
    logic                 fault_q, fault_d;
    logic [CHANNELS+1:0]  flags_q, flags_d, flags_set;
    logic [CHANNELS-1:0]  match;
    logic                 tick;
    logic                 uev;
    logic                 fault_set;

    assign running   = (st_q == ST_RUN);
    assign tick      = running & en & (pre_q == prescale);
    assign fault_set = fault & fault_en;

    always_comb begin
        st_d    = st_q;
        pre_d   = pre_q;
        count_d = count_q;
        dir_d   = dir_q;
        psh_d   = psh_q;
        uev     = 1'b0;
        if (!en) begin
            st_d    = ST_IDLE;
            pre_d   = '0;
            dir_d   = 1'b0;
            count_d = (mode == MODE_DOWN) ? period : '0;
            psh_d   = period;
        end else begin
            case (st_q)
                ST_IDLE: st_d = ST_RUN;
                ST_RUN: begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        case (mode)
                            MODE_DOWN: begin
                                if (count_q == '0) begin
                                    count_d = psh_q;
                                    uev     = 1'b1;
                                end else begin
                                    count_d = count_q - 1'b1;
                                end
                            end
                            MODE_CENTER: begin
                                // A zero period degenerates to a UEV on every tick.
                                if (psh_q == '0) begin
                                    count_d = '0;
                                    uev     = 1'b1;
                                end else if (!dir_q) begin
                                    if (count_q == psh_q) begin
                                        dir_d   = 1'b1;
                                        count_d = psh_q - 1'b1;
                                    end else begin
                                        count_d = count_q + 1'b1;
                                    end
                                end else begin
                                    if (count_q == '0) begin
                                        dir_d   = 1'b0;
                                        count_d = WIDTH'(1);
                                        uev     = 1'b1;
                                    end else begin
                                        count_d = count_q - 1'b1;
                                    end
                                end
                            end
                            default: begin
                                if (count_q == psh_q) begin
                                    count_d = '0;
                                    uev     = 1'b1;
                                end else begin
                                    count_d = count_q + 1'b1;
                                end
                            end
                        endcase
                        if (uev) begin
                            psh_d = period;
                            if (one_shot) begin
                                st_d = ST_DONE;
                            end
                        end
                    end
                end
                default: st_d = ST_DONE;
            endcase
        end
    end

    always_comb begin
        fault_d = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (fault_clr && !fault) begin
            fault_d = 1'b0;
        end
        flags_set                     = '0;
        flags_set[FLG_UEV]            = uev;
        flags_set[FLG_FAULT]          = fault_set;
        flags_set[CHANNELS+1:FLG_MATCH0] = match;
        flags_d = (flags_q & ~flag_clr) | flags_set;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            st_q    <= ST_IDLE;
            pre_q   <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            psh_q   <= '0;
            fault_q <= 1'b0;
            flags_q <= '0;
        end else begin
            st_q    <= st_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            psh_q   <= psh_d;
            fault_q <= fault_d;
            flags_q <= flags_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tmr_pwm_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .PCLK      (PCLK),
            .PRESET    (PRESET),
            .cmp_in    (cmp[i*WIDTH +: WIDTH]),
            .load      (~en | uev),
            .tick      (tick),
            .count_next(count_d),
            .running   (running),
            .fault_q   (fault_q),
            .pol       (pol[i]),
            .pwm       (pwm[i]),
            .match     (match[i])
        );
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_tmr_pwm_core.sv
// Directed bench for tmr_pwm_core with hand-computed expectations.
module tb_tmr_pwm_core;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        en;
    logic [1:0]  mode;
    logic        one_shot;
    logic [15:0] prescale;
    logic [31:0] period;
    logic [63:0] cmp;
    logic [1:0]  pol;
    logic        fault;
    logic        fault_en;
    logic        fault_clr;
    logic [3:0]  flag_clr;
    logic [31:0] count;
    logic        dir;
    logic        running;
    logic [1:0]  pwm;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    int cseq [0:10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    int dseq [0:10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    always #5 PCLK = ~PCLK;

    tmr_pwm_core #(
        .WIDTH   (32),
        .CHANNELS(2),
        .PRE_W   (16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .en       (en),
        .mode     (mode),
        .one_shot (one_shot),
        .prescale (prescale),
        .period   (period),
        .cmp      (cmp),
        .pol      (pol),
        .fault    (fault),
        .fault_en (fault_en),
        .fault_clr(fault_clr),
        .flag_clr (flag_clr),
        .count    (count),
        .dir      (dir),
        .running  (running),
        .pwm      (pwm),
        .flags    (flags)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] epwm;
        int t;
        PRESET = 1'b1; en = 1'b0; mode = 2'b00; one_shot = 1'b0; prescale = '0;
        period = '0; cmp = '0; pol = 2'b10; fault = 1'b0; fault_en = 1'b0;
        fault_clr = 1'b0; flag_clr = '0;
        cyc(2);
        chk("rst_count", count, 0);
        chk("rst_dir", dir, 0);
        chk("rst_running", running, 0);
        chk("rst_pwm", pwm, 2'b10);
        chk("rst_flags", flags, 0);

        // Up mode, period 9, cmp0 3, cmp1 beyond period
        PRESET = 1'b0; pol = 2'b00; period = 32'd9; cmp = {32'd12, 32'd3};
        cyc(2);
        chk("up_idle_count", count, 0);
        en = 1'b1;
        cyc(1);
        chk("up_start_running", running, 1);
        chk("up_start_count", count, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            chk("up_count", count, i % 10);
            epwm = {1'b1, ((i % 10) < 3)};
            chk("up_pwm", pwm, epwm);
            if (i == 3) chk("up_match_flag", flags, 4'b0100);
            if (i == 9) chk("up_no_uev_yet", flags, 4'b0100);
            if (i == 10) chk("up_uev_flag", flags, 4'b0101);
        end
        flag_clr = 4'hF;
        cyc(1);
        flag_clr = '0;
        chk("flag_clr_all", flags, 0);
        cyc(8);
        chk("pre_uev_count", count, 9);
        flag_clr = 4'b0001;
        cyc(1);
        flag_clr = '0;
        chk("clr_vs_uev_set_wins", flags[0], 1);

        // Shadow reload: change period at count 5
        cyc(5);
        chk("shadow_at5", count, 5);
        period = 32'd4;
        cyc(4);
        chk("shadow_old_top", count, 9);
        cyc(1);
        chk("shadow_wrap_old", count, 0);
        cyc(4);
        chk("shadow_new_top", count, 4);
        cyc(1);
        chk("shadow_wrap_new", count, 0);
        en = 1'b0;
        cyc(1);
        chk("idle_running", running, 0);
        chk("idle_count", count, 0);
        chk("idle_pwm", pwm, 2'b00);

        // Centre mode, prescale 1, cmp0 2, cmp1 0
        mode = 2'b10; period = 32'd4; cmp = {32'd0, 32'd2}; prescale = 16'd1;
        flag_clr = 4'hF;
        cyc(2);
        flag_clr = '0;
        en = 1'b1;
        cyc(1);
        for (int j = 1; j <= 20; j++) begin
            cyc(1);
            t = j / 2;
            chk("ctr_count", count, cseq[t]);
            chk("ctr_dir", dir, dseq[t]);
            if (t >= 1) begin
                epwm = {1'b0, (cseq[t] < 2)};
                chk("ctr_pwm", pwm, epwm);
            end
            if (j == 16) chk("ctr_flags_bottom", flags, 4'b1100);
            if (j == 18) chk("ctr_flags_uev", flags, 4'b1101);
        end
        en = 1'b0;
        cyc(1);

        // One-shot down mode, period 5
        mode = 2'b01; period = 32'd5; prescale = '0; one_shot = 1'b1; cmp = {32'd0, 32'd3};
        flag_clr = 4'hF;
        cyc(2);
        flag_clr = '0;
        chk("os_idle_count", count, 5);
        en = 1'b1;
        cyc(1);
        chk("os_start_running", running, 1);
        chk("os_start_count", count, 5);
        for (int j = 1; j <= 5; j++) begin
            cyc(1);
            chk("os_count", count, 5 - j);
        end
        cyc(1);
        chk("os_reload_count", count, 5);
        chk("os_stopped", running, 0);
        chk("os_uev", flags[0], 1);
        cyc(3);
        chk("os_no_restart", running, 0);
        chk("os_hold_count", count, 5);
        en = 1'b0;
        cyc(1);
        chk("os_idle", running, 0);
        en = 1'b1;
        cyc(1);
        chk("os_restart", running, 1);
        cyc(1);
        chk("os_restart_count", count, 4);
        en = 1'b0; one_shot = 1'b0;
        cyc(1);

        // Fault handling, pol 01
        mode = 2'b00; period = 32'd9; cmp = {32'd12, 32'd5}; pol = 2'b01; fault_en = 1'b1;
        flag_clr = 4'hF;
        cyc(2);
        flag_clr = '0;
        en = 1'b1;
        cyc(1);
        cyc(2);
        chk("flt_pre_count", count, 2);
        chk("flt_pre_pwm", pwm, 2'b10);
        fault = 1'b1;
        cyc(1);
        fault = 1'b0;
        chk("flt_safe_pwm", pwm, 2'b01);
        chk("flt_count_runs", count, 3);
        chk("flt_flag", flags[1], 1);
        cyc(1);
        chk("flt_held_pwm", pwm, 2'b01);
        chk("flt_count4", count, 4);
        fault = 1'b1; fault_en = 1'b0; fault_clr = 1'b1;
        cyc(1);
        chk("flt_clr_ignored", pwm, 2'b01);
        chk("flt_count5", count, 5);
        fault = 1'b0; fault_en = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        chk("flt_cleared_pwm", pwm, 2'b11);
        chk("flt_count6", count, 6);
        cyc(4);
        chk("flt_resume_count", count, 0);
        chk("flt_resume_pwm", pwm, 2'b10);

        // Synchronous reset mid-run
        PRESET = 1'b1;
        cyc(1);
        PRESET = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_pwm", pwm, 2'b01);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_dir", dir, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_pwm_core.md
Name: tmr_pwm_core

Overview:
- Parametrised timer/PWM core: prescaled counter feeding CHANNELS compare channels.
- Adds up, down and centre-aligned counting, one-shot mode, shadowed period/compare, latched fault shutdown and sticky event flags.
- Sits beneath the APB register wrapper. The wrapper drives the config inputs and reads count/flags.

Parameters:
- WIDTH, 32, counter/period/compare width.
- CHANNELS, 2, number of PWM outputs (1..8).
- PRE_W, 16, prescaler width.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset, synchronous, active-high.
- en  in  1  run enable.
- mode  in  2  count mode: 00 up, 01 down, 10 up/down (centre), 11 treated as up.
- one_shot  in  1  stop after first update event.
- prescale  in  PRE_W  tick every prescale+1 cycles.
- period  in  WIDTH  period value, shadowed.
- cmp  in  CHANNELS*WIDTH  per-channel compare values, shadowed; ch i occupies bits [i*WIDTH +: WIDTH].
- pol  in  CHANNELS  output polarity; also the safe/idle level.
- fault  in  1  external fault input.
- fault_en  in  1  fault input enable.
- fault_clr  in  1  fault latch clear pulse.
- flag_clr  in  CHANNELS+2  write-1 flag clear.
- count  out  WIDTH  current count.
- dir  out  1  0 = counting up, 1 = counting down.
- running  out  1  counter active.
- pwm  out  CHANNELS  PWM outputs.
- flags  out  CHANNELS+2  bit0 update event (UEV), bit1 fault, bit 2+i match ch i.

Behaviour:
- Reset (sync, PRESET=1): count=0, dir=0, running=0, prescaler=0, shadows=0, fault latch=0, flags=0. pwm=pol.
- Idle (en=0):
  - running=0, prescaler=0, done latch cleared.
  - count = period in down mode, else 0. dir=0.
  - Shadows track period/cmp every cycle.
- Start: first cycle sampled en=1 with done=0 -> running=1. First tick ≥ prescale+1 cycles later.
- Tick: prescaler counts 0..prescale and asserts tick when equal, then wraps to 0. prescale=0 -> tick every cycle. The counter moves only on tick while running.
- Up mode: count==period_sh -> count←0, UEV; else count+1.
- Down mode: count==0 -> count←period_sh, UEV; else count-1.
- Up/down mode:
  - dir=0 and count==period_sh -> dir←1, count←period_sh-1.
  - dir=1 and count==0 -> dir←0, count←1, UEV.
  - period_sh=0 -> count stays 0, UEV every tick.
- UEV, same edge: period_sh←period, cmp_sh←cmp, flags[0] set.
  - If one_shot: running←0, done←1, and count holds its reloaded value.
  - Restart requires en low then high.
- Compare: raw_i registered on tick = (count_next < cmp_sh_i). cmp_sh_i=0 -> always inactive. cmp_sh_i>period_sh -> always active.
- Output: pwm_i = pol_i ^ (raw_i & running & ~fault_q), combinational from registers.
- Match: flags[2+i] set on the tick where count_next==cmp_sh_i while running.
- Fault:
  - fault_q set the cycle after fault&fault_en is sampled; pwm at safe level in that same cycle.
  - Counter keeps running during fault. flags[1] mirrors the set event.
  - fault_clr clears fault_q only when fault is low. Set wins over clear.
- Flags: sticky. A flag_clr bit clears its flag; a same-cycle set wins.
- Mode, one_shot and prescale changes while running take effect immediately (not shadowed). Software changes them only while en=0.
- Arithmetic: unsigned WIDTH bits, no overflow possible since count ≤ period_sh.
- PRESET mid-run: all state returns to reset values on that edge; pwm=pol in the next cycle.

Decomposition:
- Package tmr_pkg:
  - mode enum (MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_CENTER=2'b10).
  - flag index constants FLG_UEV=0, FLG_FAULT=1, FLG_MATCH0=2.
- Sub-module tmr_pwm_ch, instantiated CHANNELS times in a generate loop.
  - Holds: cmp shadow, raw compare register, match detect, polarity/fault gating.
- Counter, prescaler, fault latch and flags stay in the top module.

Test Plan:
- Up mode, WIDTH=32, prescale=0, period=9, cmp0=3, pol=0 -> count 0..9 repeating, pwm0 high 3 of 10 cycles, flags[0] set on each wrap, flags[2] set at count 3.
- Centre mode, period=4, cmp0=2, prescale=1 -> count 0,1,2,3,4,3,2,1,0 (2 cycles each), dir toggles at 4 and 0, pwm0 symmetric high around 0, UEV only at bottom.
- Shadow reload: up mode, period=9; write period=4 mid-cycle at count=5 -> counter still wraps at 9, then wraps at 4.
- One-shot down mode, period=5 -> counts 5..0, reload to 5, running=0; en held high -> no restart; en low then high -> restarts.
- Fault: fault_en=1, pol=2'b01, running; fault pulse 1 cycle -> pwm=2'b01 the next cycle and held, count continues. fault_clr while fault=1 -> ignored. fault_clr after fault low -> PWM resumes on the next compare update.
- Boundaries: cmp0=0 -> pwm0=pol0 constant; cmp0=period+1 -> always active. flag_clr[0] coincident with UEV -> flags[0] stays 1. PRESET mid-run -> count=0, pwm=pol next cycle.
